wrr_pkt_arbiter: RTL and testbench

- Packet-level weighted round-robin arbiter: merges REQ_NUM valid/ready/last input streams onto one output stream.
- Once granted, a requester holds the output until its last beat transfers. Each requester may send up to its weight in consecutive packets before the grant rotates.
- Sits in front of the shared output channel that the existing requester streams drive; also reports which requester holds the grant.

---
 rtl/wrr_pkt_arbiter_pkg.sv | 18 +
 rtl/wrr_pkt_arbiter_rr_pick.sv | 36 +++
 rtl/wrr_pkt_arbiter.sv | 104 ++++++++++
 tb/tb_wrr_pkt_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_pkt_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
// IDX_W describes the default 8-requester build; modules derive their own index width.
package wrr_pkt_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int REQ_NUM_DEF = 8;
    localparam int IDX_W       = $clog2(REQ_NUM_DEF);

    // A zero weight still grants one packet per turn.
    function automatic int max_one(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wrr_pkt_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req after ptr, wrapping modulo REQ_NUM.
// When only req[ptr] is set, ptr itself wins, since it is searched last.
module rr_pick #(
    parameter int REQ_NUM = 8
) (
    input  logic [REQ_NUM-1:0]         req,
    input  logic [$clog2(REQ_NUM)-1:0] ptr,
    output logic [$clog2(REQ_NUM)-1:0] winner,
    output logic                       any
);

    localparam int IW = $clog2(REQ_NUM);

    logic [IW-1:0]      cand [REQ_NUM];
    logic [REQ_NUM-1:0] hit;

    // cand[gi] is the requester at search distance gi+1 from ptr.
    generate
        for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_rot
            assign cand[gi] = IW'((int'(ptr) + gi + 1) % REQ_NUM);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        winner = ptr;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner = cand[k];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Packet-level weighted round-robin arbiter merging REQ_NUM valid/ready/last streams.
// The granted stream passes combinationally; one IDLE cycle separates packets.
module wrr_pkt_arbiter
    import wrr_pkt_arbiter_pkg::*;
#(
    parameter int REQ_NUM = 8,
    parameter int DATA_W  = 1,
    parameter int WGT_W   = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [REQ_NUM-1:0]          valid_in,
    input  logic [REQ_NUM*DATA_W-1:0]   data_in,
    input  logic [REQ_NUM-1:0]          last_in,
    output logic [REQ_NUM-1:0]          ready_in,
    input  logic [REQ_NUM*WGT_W-1:0]    weight,
    output logic                        valid_out,
    output logic [DATA_W-1:0]           data_out,
    output logic                        last_out,
    input  logic                        ready_out,
    output logic [$clog2(REQ_NUM)-1:0]  grant_id,
    output logic                        busy
);

    localparam int GID_W = $clog2(REQ_NUM);

    state_t             state_reg, state_next;
    logic [GID_W-1:0]   grant_reg, grant_next;
    logic [GID_W-1:0]   ptr_reg, ptr_next;
    logic [WGT_W-1:0]   credit_reg, credit_next;
    logic [GID_W-1:0]   pick;
    logic               any;
    logic               last_fire;

    rr_pick #(.REQ_NUM(REQ_NUM)) u_pick (
        .req    (valid_in),
        .ptr    (ptr_reg),
        .winner (pick),
        .any    (any)
    );

    assign last_fire = (state_reg == XFER) && valid_out && ready_out && last_out;

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        ptr_next    = ptr_reg;
        credit_next = credit_reg;
        case (state_reg)
            IDLE: begin
                if (any) begin
                    state_next = XFER;
                    // Current holder keeps its turn while credit remains.
                    if ((credit_reg != '0) && valid_in[ptr_reg]) begin
                        grant_next = ptr_reg;
                    end else begin
                        grant_next  = pick;
                        ptr_next    = pick;
                        credit_next = WGT_W'(max_one(int'(weight[pick*WGT_W +: WGT_W])));
                    end
                end
            end
            XFER: begin
                if (last_fire) begin
                    state_next = IDLE;
                    if (credit_reg != '0) begin
                        credit_next = credit_reg - 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            ptr_reg    <= GID_W'(REQ_NUM - 1);
            credit_reg <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            ptr_reg    <= ptr_next;
            credit_reg <= credit_next;
        end
    end

    always_comb begin
        valid_out = 1'b0;
        data_out  = '0;
        last_out  = 1'b0;
        ready_in  = '0;
        if (state_reg == XFER) begin
            valid_out           = valid_in[grant_reg];
            data_out            = data_in[grant_reg*DATA_W +: DATA_W];
            last_out            = last_in[grant_reg];
            ready_in[grant_reg] = ready_out;
        end
    end

    assign grant_id = grant_reg;
    assign busy     = (state_reg == XFER);

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Scoreboard bench for wrr_pkt_arbiter: per-requester packet sources feed the DUT while
// the expected output beats, in predicted arbitration order, are queued for comparison.
module tb_wrr_pkt_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  valid_in = '0;
    logic [63:0] data_in = '0;
    logic [7:0]  last_in = '0;
    logic [7:0]  ready_in;
    logic [23:0] weight = '0;
    logic        valid_out;
    logic [7:0]  data_out;
    logic        last_out;
    logic        ready_out = 1'b0;
    logic [2:0]  grant_id;
    logic        busy;

    wrr_pkt_arbiter #(.REQ_NUM(8), .DATA_W(8), .WGT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .weight    (weight),
        .valid_out (valid_out),
        .data_out  (data_out),
        .last_out  (last_out),
        .ready_out (ready_out),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  src_d [8][64];
    logic        src_l [8][64];
    int          src_rd [8];
    int          src_wr [8];
    int          hold [8];
    int          acc_cnt [8];
    logic [7:0]  fired = '0;
    logic [11:0] sb [$];
    int          first_cyc [$];
    logic        rand_ready = 1'b0;
    logic        pkt_start = 1'b1;
    logic        have_last = 1'b0;
    logic        gap_check = 1'b0;
    int          last_cyc = 0;

    task automatic add_pkt(input int id, input int nbeats);
        logic [7:0] d;
        logic       l;
        for (int b = 0; b < nbeats; b++) begin
            d = 8'($urandom);
            l = (b == nbeats - 1);
            src_d[id][src_wr[id]] = d;
            src_l[id][src_wr[id]] = l;
            src_wr[id]++;
            sb.push_back({3'(id), l, d});
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 8; i++) begin
            if (fired[i]) begin
                src_rd[i]++;
                acc_cnt[i]++;
            end
        end
        fired = '0;
        ready_out = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (hold[i] > 0) begin
                valid_in[i] = 1'b0;
                hold[i]--;
            end else begin
                valid_in[i] = (src_rd[i] < src_wr[i]);
            end
            data_in[i*8 +: 8] = src_d[i][src_rd[i]];
            last_in[i]        = src_l[i][src_rd[i]];
        end
    endtask

    // One clock: monitor at the falling edge, then advance the sources after the rising edge.
    task automatic step();
        logic [11:0] e;
        @(negedge clk);
        fired = valid_in & ready_in;
        if (valid_out && ready_out) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got id=%0d last=%0d data=%h, required no beat",
                         grant_id, last_out, data_out);
            end else begin
                e = sb.pop_front();
                if ({grant_id, last_out, data_out} !== e) begin
                    fails++;
                    $display("FAIL beat: got id=%0d last=%0d data=%h, required id=%0d last=%0d data=%h",
                             grant_id, last_out, data_out, e[11:9], e[8], e[7:0]);
                end
            end
            if (pkt_start) begin
                first_cyc.push_back(cyc);
                if (gap_check && have_last) begin
                    checks++;
                    if (cyc - last_cyc !== 2) begin
                        fails++;
                        $display("FAIL packet_gap: got %0d cycles, required 2", cyc - last_cyc);
                    end
                end
            end
            pkt_start = last_out;
            if (last_out) begin
                last_cyc  = cyc;
                have_last = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            src_rd[i] = 0; src_wr[i] = 0; hold[i] = 0; acc_cnt[i] = 0;
        end
        sb.delete();
        first_cyc.delete();
        fired = '0; valid_in = '0; last_in = '0; data_in = '0; ready_out = 1'b0;
        pkt_start = 1'b1; have_last = 1'b0; gap_check = 1'b0; rand_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, valid_out, last_out, ready_in, data_out, grant_id} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%0d vout=%0d lout=%0d rdy=%b data=%h gid=%0d, required all 0",
                     busy, valid_out, last_out, ready_in, data_out, grant_id);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (ready_in !== 8'h00 || valid_out !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL idle_quiet: got rdy=%b vout=%0d busy=%0d, required 0/0/0",
                         ready_in, valid_out, busy);
            end
        end
    endtask

    task automatic test_rotation();
        do_reset();
        weight = {8{3'd1}};
        for (int k = 0; k < 9; k++) add_pkt(k % 8, 8);
        drive();
        run(300);
        checks++;
        if (first_cyc.size() !== 9) begin
            fails++;
            $display("FAIL rotation_pkts: got %0d packets, required 9", first_cyc.size());
        end else begin
            for (int k = 1; k < 9; k++) begin
                checks++;
                if (first_cyc[k] - first_cyc[k-1] !== 9) begin
                    fails++;
                    $display("FAIL rotation_spacing: got %0d cycles, required 9",
                             first_cyc[k] - first_cyc[k-1]);
                end
            end
            checks++;
            if (first_cyc[8] - first_cyc[0] !== 72) begin
                fails++;
                $display("FAIL rotation_round: got %0d cycles, required 72", first_cyc[8] - first_cyc[0]);
            end
        end
    endtask

    task automatic test_weighted();
        int order [14] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};
        do_reset();
        weight = {3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd2, 3'd1, 3'd3};
        for (int k = 0; k < 14; k++) add_pkt(order[k], 2);
        drive();
        run(300);
    endtask

    task automatic test_lock();
        logic trig = 1'b0;
        int   n = 0;
        do_reset();
        weight = {8{3'd1}};
        rand_ready = 1'b1;
        add_pkt(2, 6);
        add_pkt(5, 3);
        drive();
        while (acc_cnt[2] < 6 && n < 300) begin
            step();
            n++;
            if (acc_cnt[2] == 2 && !trig) begin
                hold[2] = 3;
                trig = 1'b1;
            end
            if (busy && acc_cnt[2] < 6) begin
                checks++;
                if (grant_id !== 3'd2 || (ready_in & 8'hFB) !== 8'h00) begin
                    fails++;
                    $display("FAIL lock_hold: got gid=%0d rdy=%b, required gid=2 no other ready",
                             grant_id, ready_in);
                end
            end
        end
        run(300);
        checks++;
        if (acc_cnt[2] !== 6) begin
            fails++;
            $display("FAIL lock_beats: got %0d beats accepted, required 6", acc_cnt[2]);
        end
    endtask

    task automatic test_sole();
        int lens [6] = '{1, 2, 3, 1, 1, 2};
        do_reset();
        weight = {3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        for (int k = 0; k < 6; k++) add_pkt(5, lens[k]);
        gap_check = 1'b1;
        drive();
        run(200);
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset();
        weight = {8{3'd1}};
        add_pkt(0, 8);
        add_pkt(3, 2);
        drive();
        while (acc_cnt[0] < 3 && n < 100) begin
            step();
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || ready_in !== 8'h00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got vout=%0d rdy=%b busy=%0d, required 0/0/0",
                     valid_out, ready_in, busy);
        end
        do_reset();
        add_pkt(0, 2);
        add_pkt(3, 2);
        drive();
        run(100);
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_weighted();
        test_lock();
        test_sole();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
